// File: rtl/ex_pkg.sv
// ----------------------------------------------------------------------------
// ex_pkg
//   Shared definitions for the execute/memory stage:
//     - ALU operation codes carried on the 3-bit alu_op port
//     - FSM state type for ex_mem_unit
//     - width of the memory-latency down-counter
// ----------------------------------------------------------------------------
package ex_pkg;

    localparam int unsigned ALU_OP_W = 3;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_INC  = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_NEG  = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_PASS = 3'b100;

    // Counter covers MEM_LAT-1 for MEM_LAT in 1..4.
    localparam int unsigned LAT_CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MEM  = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage : ex_pkg

// File: rtl/ex_alu.sv
// ----------------------------------------------------------------------------
// ex_alu
//   Combinational ALU for the execute stage. All arithmetic wraps modulo
//   2**DATA_W; reserved op codes produce zero.
//   Ports:
//     a      in  DATA_W  operand A
//     b      in  DATA_W  operand B (already muxed between rd2 and imm)
//     op     in  3       operation code (ex_pkg ALU_*)
//     result out DATA_W  ALU result
//     zero   out 1       result == 0
//     neg    out 1       result MSB
// ----------------------------------------------------------------------------
module ex_alu
    import ex_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [ALU_OP_W-1:0] op,
    output logic [DATA_W-1:0]   result,
    output logic                zero,
    output logic                neg
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_INC:  result = a + DATA_W'(1);
            ALU_NEG:  result = '0 - b;
            ALU_PASS: result = b;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);
    assign neg  = result[DATA_W-1];

endmodule : ex_alu

// File: rtl/ex_mem_unit.sv
// ----------------------------------------------------------------------------
// ex_mem_unit
//   Execute/memory pipeline stage. Accepts one operation under a valid/ready
//   handshake, computes an ALU result with Z/N flags, optionally accesses an
//   internal data memory with MEM_LAT cycles of latency, then holds the
//   response until the consumer accepts it. One operation in flight.
//   Ports:
//     clock      in   1       rising-edge clock
//     reset_n    in   1       asynchronous active-low reset
//     in_valid   in   1       operation offered
//     in_ready   out  1       unit can accept (IDLE and not in reset)
//     mem_write  in   1       store rd2 at address rd1
//     mem_read   in   1       load from address rd1
//     alu_src    in   1       operand B select: 1 = imm, 0 = rd2
//     alu_op     in   3       ALU operation code
//     rd1        in   DATA_W  operand A / memory address
//     rd2        in   DATA_W  operand B / store data
//     imm        in   DATA_W  immediate operand
//     out_valid  out  1       response held
//     out_ready  in   1       consumer accepts response
//     result     out  DATA_W  ALU result
//     read_data  out  DATA_W  load data (0 if no load)
//     zero       out  1       result == 0
//     neg        out  1       result MSB
//     busy       out  1       operation in progress
// ----------------------------------------------------------------------------
module ex_mem_unit
    import ex_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned MEM_DEPTH = 65536,
    parameter int unsigned MEM_LAT   = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                mem_write,
    input  logic                mem_read,
    input  logic                alu_src,
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [DATA_W-1:0]   rd1,
    input  logic [DATA_W-1:0]   rd2,
    input  logic [DATA_W-1:0]   imm,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   result,
    output logic [DATA_W-1:0]   read_data,
    output logic                zero,
    output logic                neg,
    output logic                busy
);

    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    state_t state, state_next;

    logic [LAT_CNT_W-1:0] cnt;

    // Operation captured at accept; later input changes are ignored.
    logic [ALU_OP_W-1:0] op_q;
    logic                src_q;
    logic                mr_q;
    logic                mw_q;
    logic [DATA_W-1:0]   rd1_q;
    logic [DATA_W-1:0]   rd2_q;
    logic [DATA_W-1:0]   imm_q;

    logic [DATA_W-1:0]   alu_b;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_zero;
    logic                alu_neg;

    logic [DATA_W-1:0]   result_q;
    logic [DATA_W-1:0]   read_data_q;
    logic                zero_q;
    logic                neg_q;

    logic [ADDR_W-1:0]   addr;
    logic [IDX_W-1:0]    idx;
    logic                in_range;
    logic                commit;
    logic [DATA_W-1:0]   load_word;

    logic [DATA_W-1:0]   mem [MEM_DEPTH];

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    assign alu_b = src_q ? imm_q : rd2_q;

    ex_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (rd1_q),
        .b      (alu_b),
        .op     (op_q),
        .result (alu_result),
        .zero   (alu_zero),
        .neg    (alu_neg)
    );

    // ------------------------------------------------------------------
    // Memory addressing
    // ------------------------------------------------------------------
    assign addr     = rd1_q[ADDR_W-1:0];
    assign idx      = addr[IDX_W-1:0];
    assign in_range = ({1'b0, addr} < (ADDR_W+1)'(MEM_DEPTH));

    // The access happens on the edge that leaves MEM; an abort by reset
    // before that edge therefore never reaches the array.
    assign commit = (state == MEM) && (cnt == '0);

    // Write-first: a combined store/load returns the store data.
    assign load_word = !in_range ? '0 :
                       mw_q      ? rd2_q :
                                   mem[idx];

    always_ff @(posedge clock) begin
        if (commit && mw_q && in_range) begin
            mem[idx] <= rd2_q;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = EXEC;
            EXEC: state_next = (mr_q || mw_q) ? MEM : RESP;
            MEM:  if (cnt == '0) state_next = RESP;
            RESP: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Capture, result and latency-counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q        <= '0;
            src_q       <= 1'b0;
            mr_q        <= 1'b0;
            mw_q        <= 1'b0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            imm_q       <= '0;
            result_q    <= '0;
            read_data_q <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q  <= alu_op;
                        src_q <= alu_src;
                        mr_q  <= mem_read;
                        mw_q  <= mem_write;
                        rd1_q <= rd1;
                        rd2_q <= rd2;
                        imm_q <= imm;
                    end
                end
                EXEC: begin
                    result_q <= alu_result;
                    zero_q   <= alu_zero;
                    neg_q    <= alu_neg;
                    if (!mr_q) begin
                        read_data_q <= '0;
                    end
                    if (mr_q || mw_q) begin
                        cnt <= LAT_CNT_W'(MEM_LAT - 1);
                    end
                end
                MEM: begin
                    if (cnt == '0) begin
                        if (mr_q) begin
                            read_data_q <= load_word;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = (state == IDLE) && reset_n;
    assign busy      = (state != IDLE);
    assign out_valid = (state == RESP);
    assign result    = result_q;
    assign read_data = read_data_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

endmodule : ex_mem_unit

// File: tb/tb_ex_mem_unit.sv
// ----------------------------------------------------------------------------
// tb_ex_mem_unit
//   Self-checking bench for ex_mem_unit (DATA_W=32, ADDR_W=8, MEM_DEPTH=200,
//   MEM_LAT=3): a directed vector table, hand-written reset/backpressure
//   sequences, and randomized operations checked against a reference model.
// ----------------------------------------------------------------------------
module tb_ex_mem_unit;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 200;
    localparam int LAT   = 3;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          mem_write = 1'b0;
    logic          mem_read = 1'b0;
    logic          alu_src = 1'b0;
    logic [2:0]    alu_op = 3'd0;
    logic [DW-1:0] rd1 = '0;
    logic [DW-1:0] rd2 = '0;
    logic [DW-1:0] imm = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] result;
    logic [DW-1:0] read_data;
    logic          zero;
    logic          neg;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    ex_mem_unit #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .MEM_DEPTH (DEPTH),
        .MEM_LAT   (LAT)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .alu_src   (alu_src),
        .alu_op    (alu_op),
        .rd1       (rd1),
        .rd2       (rd2),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .read_data (read_data),
        .zero      (zero),
        .neg       (neg),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] mmem [int];

    function automatic logic [DW-1:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a + 32'd1;
            3'd3:    return 32'd0 - b;
            3'd4:    return b;
            default: return 32'd0;
        endcase
    endfunction

    // Applies the memory side effect and returns the expected read_data;
    // known=0 when the load hits a word never written by this bench.
    task automatic mem_ref(input logic mr, input logic mw, input logic [DW-1:0] a,
                           input logic [DW-1:0] d, output logic known, output logic [DW-1:0] rdat);
        int adr;
        adr   = int'(a % (1 << AW));
        known = 1'b1;
        rdat  = '0;
        if (adr < DEPTH) begin
            if (mw) mmem[adr] = d;
            if (mr) begin
                if (mmem.exists(adr)) rdat = mmem[adr];
                else known = 1'b0;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Runs one operation from IDLE (called #1 after a rising edge) through
    // acceptance of its response.
    task automatic do_op(input string nm, input logic [2:0] op, input logic src, input logic mr,
                         input logic mw, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] im, input logic [DW-1:0] e_res,
                         input logic rd_known, input logic [DW-1:0] e_rd,
                         input int hold, input logic poke);
        int edges;
        int e_lat;
        e_lat = (mr || mw) ? 2 + LAT : 2;
        chk({nm, ".in_ready_idle"}, in_ready, 1);
        alu_op = op; alu_src = src; mem_read = mr; mem_write = mw;
        rd1 = a; rd2 = b; imm = im; in_valid = 1'b1;
        @(posedge clock);
        #1;
        // Scramble inputs after acceptance: the unit must use captured values.
        in_valid = 1'b0;
        alu_op = 3'($urandom()); alu_src = 1'($urandom()); mem_read = 1'($urandom());
        mem_write = 1'($urandom()); rd1 = $urandom(); rd2 = $urandom(); imm = $urandom();
        edges = 1;
        while (!out_valid && edges < 20) begin
            @(posedge clock);
            edges++;
            #1;
        end
        chk({nm, ".latency"}, 32'(edges), 32'(e_lat));
        chk({nm, ".result"}, result, e_res);
        chk({nm, ".zero"}, zero, (e_res == 0));
        chk({nm, ".neg"}, neg, e_res[DW-1]);
        if (rd_known) chk({nm, ".read_data"}, read_data, e_rd);
        chk({nm, ".busy_resp"}, busy, 1);
        chk({nm, ".in_ready_resp"}, in_ready, 0);
        if (poke) begin
            in_valid = 1'b1; alu_op = 3'd0; alu_src = 1'b0;
            mem_read = 1'b0; mem_write = 1'b0; rd1 = $urandom(); rd2 = $urandom();
        end
        for (int k = 0; k < hold; k++) begin
            @(posedge clock);
            #1;
            chk({nm, ".hold_valid"}, out_valid, 1);
            chk({nm, ".hold_result"}, result, e_res);
            chk({nm, ".hold_in_ready"}, in_ready, 0);
            if (rd_known) chk({nm, ".hold_read_data"}, read_data, e_rd);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        chk({nm, ".out_valid_drop"}, out_valid, 0);
        chk({nm, ".idle_after"}, busy, 0);
    endtask

    typedef struct {
        logic [2:0]    op;
        logic          src;
        logic          mr;
        logic          mw;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] im;
        logic [DW-1:0] e_res;
        logic [DW-1:0] e_rd;
        int            hold;
        logic          poke;
    } vec_t;

    vec_t vecs[15];

    initial begin
        logic          known;
        logic [DW-1:0] rdat;
        logic [2:0]    op;
        logic          src, mr, mw;
        logic [DW-1:0] a, b, im, e_res;
        int            kind;

        //            op    src   mr    mw    rd1           rd2           imm           result        read_data    hold poke
        vecs[0]  = '{3'd0, 1'b0, 1'b0, 1'b0, 32'd5,        32'd7,        32'd0,        32'd12,       32'd0,       0,   1'b0};
        vecs[1]  = '{3'd1, 1'b1, 1'b0, 1'b0, 32'd3,        32'd99,       32'd3,        32'd0,        32'd0,       1,   1'b0};
        vecs[2]  = '{3'd3, 1'b0, 1'b0, 1'b0, 32'd0,        32'd1,        32'd0,        32'hFFFFFFFF, 32'd0,       2,   1'b0};
        vecs[3]  = '{3'd2, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd5,        32'd0,        32'd0,        32'd0,       0,   1'b0};
        vecs[4]  = '{3'd4, 1'b1, 1'b0, 1'b0, 32'd1,        32'd2,        32'h80000000, 32'h80000000, 32'd0,       4,   1'b1};
        vecs[5]  = '{3'd1, 1'b0, 1'b0, 1'b0, 32'd0,        32'd1,        32'd0,        32'hFFFFFFFF, 32'd0,       0,   1'b0};
        vecs[6]  = '{3'd5, 1'b0, 1'b0, 1'b0, 32'd9,        32'd9,        32'd9,        32'd0,        32'd0,       1,   1'b0};
        vecs[7]  = '{3'd7, 1'b1, 1'b0, 1'b0, 32'h1234,     32'h55,       32'h66,       32'd0,        32'd0,       0,   1'b0};
        vecs[8]  = '{3'd0, 1'b1, 1'b0, 1'b1, 32'd4,        32'hAB,       32'd0,        32'd4,        32'd0,       0,   1'b0};
        vecs[9]  = '{3'd0, 1'b1, 1'b1, 1'b0, 32'h104,      32'd0,        32'd0,        32'h104,      32'hAB,      2,   1'b0};
        vecs[10] = '{3'd4, 1'b0, 1'b0, 1'b1, 32'd200,      32'h55,       32'd0,        32'h55,       32'd0,       0,   1'b0};
        vecs[11] = '{3'd2, 1'b0, 1'b1, 1'b0, 32'd200,      32'd0,        32'd0,        32'd201,      32'd0,       0,   1'b0};
        vecs[12] = '{3'd4, 1'b0, 1'b1, 1'b1, 32'd7,        32'h77,       32'd0,        32'h77,       32'h77,      1,   1'b0};
        vecs[13] = '{3'd0, 1'b1, 1'b1, 1'b0, 32'd7,        32'd0,        32'd1,        32'd8,        32'h77,      0,   1'b0};
        vecs[14] = '{3'd4, 1'b1, 1'b0, 1'b0, 32'd0,        32'd0,        32'h1234,     32'h1234,     32'd0,       0,   1'b0};

        // ---------------- reset state ----------------
        repeat (2) @(posedge clock);
        #1;
        chk("reset.in_ready", in_ready, 0);
        chk("reset.out_valid", out_valid, 0);
        chk("reset.busy", busy, 0);
        chk("reset.result", result, 0);
        chk("reset.read_data", read_data, 0);
        chk("reset.zero", zero, 0);
        chk("reset.neg", neg, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("reset.release_in_ready", in_ready, 1);

        // ---------------- directed table ----------------
        foreach (vecs[i]) begin
            mem_ref(vecs[i].mr, vecs[i].mw, vecs[i].a, vecs[i].b, known, rdat);
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].src, vecs[i].mr, vecs[i].mw,
                  vecs[i].a, vecs[i].b, vecs[i].im, vecs[i].e_res, 1'b1, vecs[i].e_rd,
                  vecs[i].hold, vecs[i].poke);
        end

        // ---------------- reset mid-EXEC ----------------
        alu_op = 3'd0; alu_src = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        rd1 = 32'd1; rd2 = 32'd2; in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        chk("rst_exec.busy_before", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_exec.result", result, 0);
        chk("rst_exec.read_data", read_data, 0);
        chk("rst_exec.zero", zero, 0);
        chk("rst_exec.neg", neg, 0);
        chk("rst_exec.out_valid", out_valid, 0);
        chk("rst_exec.busy", busy, 0);
        chk("rst_exec.in_ready", in_ready, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_exec.in_ready_after", in_ready, 1);

        // ---------------- reset while in MEM: store never commits ----------------
        mem_ref(1'b0, 1'b1, 32'd10, 32'h11, known, rdat);
        do_op("rst_mem.store1", 3'd4, 1'b0, 1'b0, 1'b1, 32'd10, 32'h11, 32'd0, 32'h11, 1'b1, 32'd0, 0, 1'b0);
        alu_op = 3'd4; alu_src = 1'b0; mem_read = 1'b0; mem_write = 1'b1;
        rd1 = 32'd10; rd2 = 32'h22; in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("rst_mem.busy_in_mem", busy, 1);
        chk("rst_mem.no_valid_in_mem", out_valid, 0);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        mem_ref(1'b1, 1'b0, 32'd10, 32'd0, known, rdat);
        do_op("rst_mem.load", 3'd0, 1'b1, 1'b1, 1'b0, 32'd10, 32'd0, 32'd0, 32'd10, known, rdat, 0, 1'b0);

        // ---------------- randomized operations ----------------
        for (int n = 0; n < 150; n++) begin
            op  = 3'($urandom_range(0, 7));
            src = 1'($urandom());
            a   = $urandom();
            b   = $urandom();
            im  = $urandom();
            kind = $urandom_range(0, 3);
            mr  = (kind == 1) || (kind == 3);
            mw  = (kind == 2) || (kind == 3);
            if (mr || mw) begin
                if ($urandom_range(0, 3) == 0) a[AW-1:0] = 8'(196 + $urandom_range(0, 7));
                else a[AW-1:0] = 8'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 7) == 0) begin
                b = a; im = a;
            end
            e_res = ref_alu(op, a, src ? im : b);
            mem_ref(mr, mw, a, b, known, rdat);
            do_op($sformatf("rnd%0d", n), op, src, mr, mw, a, b, im, e_res, known, rdat,
                  $urandom_range(0, 2), 1'($urandom_range(0, 5) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ex_mem_unit
